// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Read-only window: map index, adjacency lists and LED patterns.
    localparam int unsigned MAP_BASE = 33;
    localparam int unsigned LED_END  = 224;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_HOST = 1'b1
    } port_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes and memory pins of the arbiter, bundled as one interface.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // Port 0: CPU load/store unit
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_lock;
    logic              m0_gnt;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    // Port 1: host/debug loader
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    // Single-port memory pins
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Environment side: requesters and the memory itself
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_ack, m1_rdata, m1_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_ack, m1_rdata, m1_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker with a port-0 priority lock.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_lock0,
    output logic o_gnt0,
    output logic o_gnt1
);

    port_id_e r_last_grant;
    logic     w_gnt0;
    logic     w_gnt1;

    // Pick a winner this cycle; nothing is granted while reset is held
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (i_req0 && i_req1) begin
                if (i_lock0 || (r_last_grant == PORT_HOST)) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = i_req0;
                w_gnt1 = i_req1;
            end
        end
    end

    assign o_gnt0 = w_gnt0;
    assign o_gnt1 = w_gnt1;

    // Remember the last winner; reset favours port 0 for the first contest
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= PORT_HOST;
        end else if (w_gnt0) begin
            r_last_grant <= PORT_CPU;
        end else if (w_gnt1) begin
            r_last_grant <= PORT_HOST;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between the CPU and the host loader:
// grant in cycle N, memory access in N+1, ack with read data in N+2.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter int          DATA_W  = DATA_W_DEF,
    parameter logic        PROT_EN = 1'b1,
    parameter int unsigned PROT_LO = MAP_BASE,
    parameter int unsigned PROT_HI = LED_END
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_gnt_any;
    logic              w_we_p0;
    logic [ADDR_W-1:0] w_addr_p0;
    logic [DATA_W-1:0] w_wdata_p0;
    logic              w_prot_p0;

    logic              r_mem_we_p1;
    logic [ADDR_W-1:0] r_mem_addr_p1;
    logic [DATA_W-1:0] r_mem_wdata_p1;
    logic              r_vld_p1;
    port_id_e          r_port_p1;
    logic              r_prot_p1;

    logic              r_ack0_p2;
    logic              r_ack1_p2;
    logic              r_err0_p2;
    logic              r_err1_p2;
    logic [DATA_W-1:0] r_rdata0_p2;
    logic [DATA_W-1:0] r_rdata1_p2;

    // A write into the read-only window is dropped; reads always pass.
    function automatic logic prot_hit(input logic we, input logic [ADDR_W-1:0] addr);
        prot_hit = PROT_EN && we && (32'(addr) >= PROT_LO) && (32'(addr) <= PROT_HI);
    endfunction

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_req0  (bus.m0_req),
        .i_req1  (bus.m1_req),
        .i_lock0 (bus.m0_lock),
        .o_gnt0  (w_gnt0),
        .o_gnt1  (w_gnt1)
    );

    assign w_gnt_any  = w_gnt0 | w_gnt1;
    assign w_we_p0    = w_gnt1 ? bus.m1_we    : bus.m0_we;
    assign w_addr_p0  = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
    assign w_wdata_p0 = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
    assign w_prot_p0  = prot_hit(w_we_p0, w_addr_p0);

    assign bus.m0_gnt = w_gnt0;
    assign bus.m1_gnt = w_gnt1;

    // Stage 0 -> 1: drive the memory pins from the winner and tag the access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we_p1    <= 1'b0;
            r_mem_addr_p1  <= '0;
            r_mem_wdata_p1 <= '0;
            r_vld_p1       <= 1'b0;
            r_port_p1      <= PORT_CPU;
            r_prot_p1      <= 1'b0;
        end else begin
            r_vld_p1    <= w_gnt_any;
            r_mem_we_p1 <= w_gnt_any && w_we_p0 && !w_prot_p0;
            if (w_gnt_any) begin
                r_mem_addr_p1  <= w_addr_p0;
                r_mem_wdata_p1 <= w_wdata_p0;
                r_port_p1      <= w_gnt1 ? PORT_HOST : PORT_CPU;
                r_prot_p1      <= w_prot_p0;
            end
        end
    end

    // The memory commits on the same edge that applies reset, so mem_we is
    // gated by rst to discard an in-flight write.
    assign bus.mem_we    = r_mem_we_p1 && !rst;
    assign bus.mem_addr  = r_mem_addr_p1;
    assign bus.mem_wdata = r_mem_wdata_p1;

    // Stage 1 -> 2: capture memory read data and strobe ack on the issuing port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack0_p2   <= 1'b0;
            r_ack1_p2   <= 1'b0;
            r_err0_p2   <= 1'b0;
            r_err1_p2   <= 1'b0;
            r_rdata0_p2 <= '0;
            r_rdata1_p2 <= '0;
        end else begin
            r_ack0_p2 <= r_vld_p1 && (r_port_p1 == PORT_CPU);
            r_ack1_p2 <= r_vld_p1 && (r_port_p1 == PORT_HOST);
            r_err0_p2 <= r_vld_p1 && (r_port_p1 == PORT_CPU)  && r_prot_p1;
            r_err1_p2 <= r_vld_p1 && (r_port_p1 == PORT_HOST) && r_prot_p1;
            if (r_vld_p1 && (r_port_p1 == PORT_CPU)) begin
                r_rdata0_p2 <= bus.mem_rdata;
            end
            if (r_vld_p1 && (r_port_p1 == PORT_HOST)) begin
                r_rdata1_p2 <= bus.mem_rdata;
            end
        end
    end

    assign bus.m0_ack   = r_ack0_p2;
    assign bus.m1_ack   = r_ack1_p2;
    assign bus.m0_err   = r_err0_p2;
    assign bus.m1_err   = r_err1_p2;
    assign bus.m0_rdata = r_rdata0_p2;
    assign bus.m1_rdata = r_rdata1_p2;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked by a
// transaction-level reference model feeding an ack scoreboard.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .PROT_EN (1'b1),
        .PROT_LO (33),
        .PROT_HI (224)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        if (a == 33) return 8'd67;
        if (a == 34) return 8'd70;
        return 8'((a * 7 + 3) & 255);
    endfunction

    function automatic logic is_prot(input logic [7:0] a);
        return (a >= 8'd33) && (a <= 8'd224);
    endfunction

    // ---------------- memory behind the arbiter ----------------
    logic [7:0] mem [256];
    bit         mem_init = 1'b0;
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic       v;
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       prot;
    } acc_t;

    typedef struct {
        logic       port;
        logic [7:0] rdata;
        logic       err;
        int         due;
    } ack_t;

    ack_t       ackq[$];
    logic [7:0] shadow [256];
    bit         sh_init     = 1'b0;
    acc_t       pend        = '{v: 1'b0, port: 1'b0, we: 1'b0, addr: 8'd0, wdata: 8'd0, prot: 1'b0};
    acc_t       nxt;
    logic       last_served = 1'b1;
    logic       eg0, eg1, ewe;
    ack_t       na;

    // Each cycle: retire last cycle's grant into memory order, predict this cycle's grant
    always @(negedge clk) begin
        if (!sh_init) begin
            for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
            sh_init = 1'b1;
        end
        ewe = 1'b0;
        if (pend.v && !rst) begin
            ewe = pend.we && !pend.prot;
            chk("mem_addr", 32'(bus.mem_addr), 32'(pend.addr));
            if (ewe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(pend.wdata));
            na.port  = pend.port;
            na.rdata = shadow[pend.addr];
            na.err   = pend.prot;
            na.due   = cyc + 1;
            ackq.push_back(na);
            if (ewe) shadow[pend.addr] = pend.wdata;
        end
        chk("mem_we", 32'(bus.mem_we), 32'(ewe));

        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!rst) begin
            if (bus.m0_req && bus.m1_req) begin
                if (bus.m0_lock || last_served) eg0 = 1'b1;
                else eg1 = 1'b1;
            end else begin
                eg0 = bus.m0_req;
                eg1 = bus.m1_req;
            end
        end
        chk("m0_gnt", 32'(bus.m0_gnt), 32'(eg0));
        chk("m1_gnt", 32'(bus.m1_gnt), 32'(eg1));

        nxt.v     = eg0 || eg1;
        nxt.port  = eg1;
        nxt.we    = eg1 ? bus.m1_we    : bus.m0_we;
        nxt.addr  = eg1 ? bus.m1_addr  : bus.m0_addr;
        nxt.wdata = eg1 ? bus.m1_wdata : bus.m0_wdata;
        nxt.prot  = nxt.we && is_prot(nxt.addr);
        pend      = nxt;

        if (rst) last_served = 1'b1;
        else if (eg0) last_served = 1'b0;
        else if (eg1) last_served = 1'b1;
    end

    // ---------------- ack monitor / scoreboard ----------------
    bit         mon_prev_rst = 1'b0;
    bit         mon_armed    = 1'b0;
    logic [7:0] hold0, hold1;
    logic       ea0, ea1;
    ack_t       e;

    // Pop the expected response whenever one is due and compare the port outputs
    always @(negedge clk) begin
        if (mon_prev_rst) begin
            chk("rst_m0_ack",   32'(bus.m0_ack),    0);
            chk("rst_m1_ack",   32'(bus.m1_ack),    0);
            chk("rst_m0_rdata", 32'(bus.m0_rdata),  0);
            chk("rst_m1_rdata", 32'(bus.m1_rdata),  0);
            chk("rst_m0_err",   32'(bus.m0_err),    0);
            chk("rst_m1_err",   32'(bus.m1_err),    0);
            chk("rst_mem_addr", 32'(bus.mem_addr),  0);
            chk("rst_mem_wdata",32'(bus.mem_wdata), 0);
            hold0     = 8'd0;
            hold1     = 8'd0;
            mon_armed = 1'b1;
        end else if (mon_armed) begin
            ea0 = 1'b0;
            ea1 = 1'b0;
            if (ackq.size() > 0 && ackq[0].due == cyc) begin
                e = ackq.pop_front();
                if (e.port) begin
                    ea1 = 1'b1;
                    chk("m1_rdata", 32'(bus.m1_rdata), 32'(e.rdata));
                    chk("m1_err",   32'(bus.m1_err),   32'(e.err));
                    hold1 = e.rdata;
                end else begin
                    ea0 = 1'b1;
                    chk("m0_rdata", 32'(bus.m0_rdata), 32'(e.rdata));
                    chk("m0_err",   32'(bus.m0_err),   32'(e.err));
                    hold0 = e.rdata;
                end
            end
            chk("m0_ack", 32'(bus.m0_ack), 32'(ea0));
            chk("m1_ack", 32'(bus.m1_ack), 32'(ea1));
            if (!ea0) chk("m0_rdata_hold", 32'(bus.m0_rdata), 32'(hold0));
            if (!ea1) chk("m1_rdata_hold", 32'(bus.m1_rdata), 32'(hold1));
        end
        mon_prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    logic       c_r0 = 0, c_w0 = 0, c_l0 = 0, c_r1 = 0, c_w1 = 0, c_rst = 1;
    logic [7:0] c_a0 = 0, c_d0 = 0, c_a1 = 0, c_d1 = 0;
    logic       g0 = 0, g1 = 0;
    logic [7:0] edges [8] = '{8'd31, 8'd32, 8'd33, 8'd34, 8'd223, 8'd224, 8'd225, 8'd226};

    task automatic apply();
        bus.m0_req   = c_r0;
        bus.m0_we    = c_w0;
        bus.m0_addr  = c_a0;
        bus.m0_wdata = c_d0;
        bus.m0_lock  = c_l0;
        bus.m1_req   = c_r1;
        bus.m1_we    = c_w1;
        bus.m1_addr  = c_a1;
        bus.m1_wdata = c_d1;
        rst          = c_rst;
        @(negedge clk);
        g0 = bus.m0_gnt;
        g1 = bus.m1_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic l0, input logic r1, input logic w1, input logic [7:0] a1,
                        input logic [7:0] d1, input logic rs);
        c_r0 = r0; c_w0 = w0; c_a0 = a0; c_d0 = d0; c_l0 = l0;
        c_r1 = r1; c_w1 = w1; c_a1 = a1; c_d1 = d1; c_rst = rs;
        apply();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [7:0] rand_addr();
        logic [7:0] a;
        if ($urandom_range(0, 1) == 0) a = edges[$urandom_range(0, 7)];
        else a = 8'($urandom_range(0, 255));
        return a;
    endfunction

    int mem_bad;

    initial begin
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // lone CPU read of addr 34
        step(1, 0, 8'd34, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // put port 1 last so the contest opens with port 0, then alternate
        step(0, 0, 0, 0, 0, 1, 0, 8'd5, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 8'd10, 0, 0, 1, 0, 8'd20, 0, 0);
        idle(3);

        // lock holds port 0, port 1 wins once the lock drops
        for (int i = 0; i < 4; i++) step(1, 0, 8'd11, 0, 1, 1, 0, 8'd21, 0, 0);
        step(1, 0, 8'd11, 0, 0, 1, 0, 8'd21, 0, 0);
        idle(3);

        // host write then CPU read-after-write at 32
        step(0, 0, 0, 0, 0, 1, 1, 8'd32, 8'h03, 0);
        step(1, 0, 8'd32, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // protection boundaries: write then read back
        step(0, 0, 0, 0, 0, 1, 1, 8'd33, 8'hFF, 0);
        step(0, 0, 0, 0, 0, 1, 0, 8'd33, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 8'd224, 8'hFF, 0);
        step(0, 0, 0, 0, 0, 1, 0, 8'd224, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 8'd225, 8'hA5, 0);
        step(0, 0, 0, 0, 0, 1, 0, 8'd225, 0, 0);
        idle(3);

        // reset right after a write grant discards it
        step(0, 0, 0, 0, 0, 1, 1, 8'd40, 8'h55, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 8'd40, 0, 0, 1, 0, 8'd41, 0, 0);
        idle(3);

        // random traffic honouring the hold-until-grant rule
        for (int k = 0; k < 2000; k++) begin
            if (c_r0 && !g0 && $urandom_range(0, 9) != 0) begin
                c_r0 = 1'b1;
            end else begin
                c_r0 = ($urandom_range(0, 9) < 6);
                c_w0 = 1'($urandom_range(0, 1));
                c_a0 = rand_addr();
                c_d0 = 8'($urandom_range(0, 255));
            end
            if (c_r1 && !g1 && $urandom_range(0, 9) != 0) begin
                c_r1 = 1'b1;
            end else begin
                c_r1 = ($urandom_range(0, 9) < 6);
                c_w1 = 1'($urandom_range(0, 1));
                c_a1 = rand_addr();
                c_d1 = 8'($urandom_range(0, 255));
            end
            c_l0  = ($urandom_range(0, 9) < 2);
            c_rst = ($urandom_range(0, 99) == 0);
            apply();
        end
        idle(6);

        chk("ackq_drained", 32'(ackq.size()), 0);
        mem_bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) mem_bad++;
        chk("mem_contents", 32'(mem_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
